// File: rtl/uart_bus_master.sv
// uart_bus_master
// Serial debug/loader initiator for the MCU memory bus. A host sends 8N1
// command frames over rxd; the block requests the bus, performs one
// single-byte read or write cycle and answers over txd.
//   Write : 0x57 addr_hi addr_lo data -> response 0x06
//   Read  : 0x52 addr_hi addr_lo      -> response is the byte read
//   Other opcode, framing error mid-command or lost grant -> response 0x15
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   rxd / txd          UART lines (idle high); rxd is asynchronous
//   bus_req / bus_gnt  bus ownership handshake (grant is a level)
//   addr, wdata, rdata bus address, write data, read data
//   wren / rden        write / read strobes, BUS_CYCLES clocks long
//   busy               high whenever a command is in progress
module uart_bus_master #(
  parameter int CLKS_PER_BIT = 30,
  parameter int BUS_CYCLES   = 4,
  parameter int TIMEOUT      = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        txd,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata,
  output logic        wren,
  output logic        rden,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BUS_CYCLES + 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] STB_LAST  = BW'(BUS_CYCLES - 1);
  localparam logic [BW-1:0] ADDR_CLR  = BW'(BUS_CYCLES);
  localparam logic [BW-1:0] REQ_DROP  = BW'(BUS_CYCLES + 1);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  // ---------------------------------------------------------------- RX ----
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic            rx_sync1_q, rx_sync2_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_ferr_q, rx_ferr_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // Re-check the line at mid start bit; a high level means it was a glitch.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        // Return to idle at mid stop bit so the next start edge is not missed.
        if (rx_cnt_q == BIT_LAST) begin
          rx_valid_d = rx_sync2_q;
          rx_ferr_d  = !rx_sync2_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_sync1_q <= rxd;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // ---------------------------------------------------------------- TX ----
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          tx_busy;

  assign tx_busy = (tx_state_q != TX_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start) begin
          tx_shift_d = tx_byte;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) tx_state_d = TX_IDLE;
        else                      tx_cnt_d   = tx_cnt_q + CW'(1);
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // -------------------------------------------------------- command FSM ----
  typedef enum logic [2:0] {
    IDLE, ADDR_H, ADDR_L, DATA, REQ, CYCLE, RESP, WAIT_TX
  } state_t;

  state_t        state_q, state_d;
  logic          is_write_q, is_write_d;
  logic [15:0]   addr_buf_q, addr_buf_d;
  logic [7:0]    data_buf_q, data_buf_d;
  logic [7:0]    resp_q, resp_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [BW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic          bus_req_q, bus_req_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          wren_q, wren_d;
  logic          rden_q, rden_d;

  assign tx_byte = resp_q;

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    addr_buf_d = addr_buf_q;
    data_buf_d = data_buf_q;
    resp_d     = resp_q;
    to_cnt_d   = to_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    bus_req_d  = bus_req_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wren_d     = wren_q;
    rden_d     = rden_q;
    tx_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid_q) begin
          to_cnt_d = '0;
          if (rx_shift_q == OP_WRITE || rx_shift_q == OP_READ) begin
            is_write_d = (rx_shift_q == OP_WRITE);
            state_d    = ADDR_H;
          end else begin
            resp_d  = RSP_NAK;
            state_d = RESP;
          end
        end
      end
      ADDR_H, ADDR_L, DATA: begin
        if (rx_ferr_q) begin
          resp_d  = RSP_NAK;
          state_d = RESP;
        end else if (rx_valid_q) begin
          to_cnt_d = '0;
          if (state_q == ADDR_H) begin
            addr_buf_d[15:8] = rx_shift_q;
            state_d          = ADDR_L;
          end else if (state_q == ADDR_L) begin
            addr_buf_d[7:0] = rx_shift_q;
            if (is_write_q) begin
              state_d = DATA;
            end else begin
              bus_req_d = 1'b1;
              state_d   = REQ;
            end
          end else begin
            data_buf_d = rx_shift_q;
            bus_req_d  = 1'b1;
            state_d    = REQ;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // Host went quiet mid-command: drop it without a response.
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      REQ: begin
        if (bus_gnt) begin
          cyc_cnt_d = '0;
          addr_d    = addr_buf_q;
          if (is_write_q) begin
            wdata_d = data_buf_q;
            wren_d  = 1'b1;
          end else begin
            rden_d = 1'b1;
          end
          state_d = CYCLE;
        end
      end
      CYCLE: begin
        // Sequence: strobe for BUS_CYCLES clocks, one clock with the strobe low
        // and addr held, one clock with addr cleared, then release the bus.
        if (cyc_cnt_q < ADDR_CLR && !bus_gnt) begin
          wren_d    = 1'b0;
          rden_d    = 1'b0;
          addr_d    = '0;
          wdata_d   = '0;
          bus_req_d = 1'b0;
          resp_d    = RSP_NAK;
          state_d   = RESP;
        end else begin
          cyc_cnt_d = cyc_cnt_q + BW'(1);
          if (cyc_cnt_q == STB_LAST) begin
            wren_d = 1'b0;
            rden_d = 1'b0;
            resp_d = is_write_q ? RSP_ACK : rdata;
          end
          if (cyc_cnt_q == ADDR_CLR) begin
            addr_d  = '0;
            wdata_d = '0;
          end
          if (cyc_cnt_q == REQ_DROP) begin
            bus_req_d = 1'b0;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = WAIT_TX;
        end
      end
      WAIT_TX: begin
        // tx_busy is already high on the first clock here.
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      addr_buf_q <= '0;
      data_buf_q <= '0;
      resp_q     <= '0;
      to_cnt_q   <= '0;
      cyc_cnt_q  <= '0;
      bus_req_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
      rden_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      addr_buf_q <= addr_buf_d;
      data_buf_q <= data_buf_d;
      resp_q     <= resp_d;
      to_cnt_q   <= to_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      bus_req_q  <= bus_req_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wren_q     <= wren_d;
      rden_q     <= rden_d;
    end
  end

  // Strobes are gated by the live grant so a withdrawn grant kills them at once.
  assign wren    = wren_q & bus_req_q & bus_gnt;
  assign rden    = rden_q & bus_req_q & bus_gnt;
  assign bus_req = bus_req_q;
  assign addr    = addr_q;
  assign wdata   = wdata_q;
  assign txd     = txd_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: drives host UART frames, models
// the bus arbiter and memory, decodes txd and compares against queued
// expectations.
module tb_uart_bus_master;
  localparam int CPB = 8;
  localparam int BC  = 4;
  localparam int TO  = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        txd;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        wren;
  logic        rden;
  logic        busy;

  always #5 clk = ~clk;

  uart_bus_master #(.CLKS_PER_BIT(CPB), .BUS_CYCLES(BC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .addr(addr), .wdata(wdata), .rdata(rdata),
    .wren(wren), .rden(rden), .busy(busy)
  );

  logic [7:0] mem [0:65535];
  assign rdata = mem[addr];

  int errors = 0;
  int checks = 0;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] st_addr_q[$];
  logic [7:0]  st_wdata_q[$];
  bit          st_wr_q[$];
  int          st_len_q[$];

  int cyc = 0;
  int req_rises = 0, viol = 0, tx_ferr = 0;
  int req_rise_cyc = 0, req_fall_cyc = 0, gnt_rise_cyc = 0;
  int st_start_cyc = 0, st_end_cyc = 0;
  int gnt_delay = 0;

  // Bus monitor / memory model, sampled on the falling edge.
  initial begin
    bit          breq_prev, gnt_prev, stb_prev, stb;
    logic [15:0] cur_addr;
    logic [7:0]  cur_wdata;
    bit          cur_wr;
    int          cur_len;
    breq_prev = 0; gnt_prev = 0; stb_prev = 0; cur_len = 0;
    cur_addr = '0; cur_wdata = '0; cur_wr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        breq_prev = 0; gnt_prev = 0; stb_prev = 0;
      end else begin
        stb = wren || rden;
        if (stb && !(bus_req && bus_gnt)) viol++;
        if (wren && rden) viol++;
        if (bus_req && !breq_prev) begin req_rises++; req_rise_cyc = cyc; end
        if (!bus_req && breq_prev) req_fall_cyc = cyc;
        if (bus_gnt && !gnt_prev) gnt_rise_cyc = cyc;
        if (stb && !stb_prev) begin
          cur_addr = addr; cur_wdata = wdata; cur_wr = wren; cur_len = 1;
          st_start_cyc = cyc;
        end else if (stb) begin
          cur_len++;
          if (addr !== cur_addr || wdata !== cur_wdata || wren !== cur_wr) viol++;
        end else if (stb_prev) begin
          st_addr_q.push_back(cur_addr);
          st_wdata_q.push_back(cur_wdata);
          st_wr_q.push_back(cur_wr);
          st_len_q.push_back(cur_len);
          st_end_cyc = cyc;
        end
        if (wren) mem[addr] = wdata;
        breq_prev = bus_req; gnt_prev = bus_gnt; stb_prev = stb;
      end
    end
  end

  // Arbiter model: grant gnt_delay clocks after the request, drop with it.
  initial begin
    int gcnt;
    gcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus_req) begin
        bus_gnt = 1'b0;
        gcnt    = 0;
      end else if (gcnt >= gnt_delay) begin
        bus_gnt = 1'b1;
      end else begin
        gcnt++;
      end
    end
  end

  // Host-side UART receiver decoding txd.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge txd);
      if (rst) continue;
      repeat (CPB / 2) @(negedge clk);
      if (txd !== 1'b0) continue;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = txd;
      end
      repeat (CPB) @(negedge clk);
      if (txd !== 1'b1) tx_ferr++;
      got_q.push_back(b);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic get_byte(output logic [7:0] b, output bit ok);
    ok = 0;
    b  = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      if (got_q.size() > 0) break;
      @(negedge clk);
    end
    if (got_q.size() > 0) begin
      b  = got_q.pop_front();
      ok = 1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || bus_req !== 1'b0 || wren !== 1'b0 || rden !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got txd=%b req=%b wren=%b rden=%b busy=%b, required 1 0 0 0 0",
               txd, bus_req, wren, rden, busy);
    end
    checks++;
    if (addr !== 16'h0000 || wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h wdata=%h, required 0000 00", addr, wdata);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [7:0] b, e;
    bit ok;
    exp_q.push_back(8'h06);
    send_byte(8'h57, 1); send_byte(8'h01, 1); send_byte(8'h23, 1); send_byte(8'hA5, 1);
    get_byte(b, ok); e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin errors++; $display("FAIL wr_resp: got %h (rx=%0d), required %h", b, ok, e); end
    checks++;
    if (st_len_q.size() != 1) begin
      errors++; $display("FAIL wr_strobe_count: got %0d, required 1", st_len_q.size());
    end else begin
      checks++;
      if (st_wr_q[0] !== 1'b1 || st_addr_q[0] !== 16'h0123 || st_wdata_q[0] !== 8'hA5 || st_len_q[0] != BC) begin
        errors++;
        $display("FAIL wr_strobe: got wr=%b addr=%h data=%h len=%0d, required 1 0123 a5 %0d",
                 st_wr_q[0], st_addr_q[0], st_wdata_q[0], st_len_q[0], BC);
      end
    end
    st_wr_q.delete(); st_addr_q.delete(); st_wdata_q.delete(); st_len_q.delete();
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_idle: busy stuck at %b, required 0", busy); end

    exp_q.push_back(8'hA5);
    send_byte(8'h52, 1); send_byte(8'h01, 1); send_byte(8'h23, 1);
    get_byte(b, ok); e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin errors++; $display("FAIL rd_resp: got %h (rx=%0d), required %h", b, ok, e); end
    checks++;
    if (st_len_q.size() != 1 || st_wr_q[0] !== 1'b0 || st_addr_q[0] !== 16'h0123 || st_len_q[0] != BC) begin
      errors++;
      $display("FAIL rd_strobe: got count=%0d, required one read of %0d clks at 0123", st_len_q.size(), BC);
    end
    st_wr_q.delete(); st_addr_q.delete(); st_wdata_q.delete(); st_len_q.delete();
    wait_idle(ok);
  endtask

  task automatic test_grant_latency();
    logic [7:0] b, e;
    bit ok;
    gnt_delay = 100;
    exp_q.push_back(8'h06);
    send_byte(8'h57, 1); send_byte(8'h00, 1); send_byte(8'h10, 1); send_byte(8'h3C, 1);
    get_byte(b, ok); e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin errors++; $display("FAIL gnt_resp: got %h (rx=%0d), required %h", b, ok, e); end
    checks++;
    if (gnt_rise_cyc - req_rise_cyc < 100 || gnt_rise_cyc - req_rise_cyc > 102) begin
      errors++; $display("FAIL gnt_wait: got %0d clks, required 100..102", gnt_rise_cyc - req_rise_cyc);
    end
    checks++;
    if (st_start_cyc !== gnt_rise_cyc + 1) begin
      errors++; $display("FAIL gnt_strobe_start: got cycle %0d, required %0d", st_start_cyc, gnt_rise_cyc + 1);
    end
    checks++;
    if (req_fall_cyc <= st_end_cyc) begin
      errors++; $display("FAIL gnt_req_fall: got cycle %0d, required after %0d", req_fall_cyc, st_end_cyc);
    end
    checks++;
    if (st_len_q.size() != 1 || st_addr_q[0] !== 16'h0010 || st_wdata_q[0] !== 8'h3C || st_len_q[0] != BC) begin
      errors++; $display("FAIL gnt_strobe: got count=%0d, required one write of 3c at 0010", st_len_q.size());
    end
    st_wr_q.delete(); st_addr_q.delete(); st_wdata_q.delete(); st_len_q.delete();
    gnt_delay = 0;
    wait_idle(ok);
  endtask

  task automatic test_bad_opcode();
    logic [7:0] b, e;
    bit ok;
    int r0;
    r0 = req_rises;
    exp_q.push_back(8'h15);
    send_byte(8'h33, 1);
    get_byte(b, ok); e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin errors++; $display("FAIL badop_resp: got %h (rx=%0d), required %h", b, ok, e); end
    checks++;
    if (req_rises != r0) begin errors++; $display("FAIL badop_noreq: got %0d requests, required 0", req_rises - r0); end
    wait_idle(ok);
    mem[16'h0200] = 8'h5C;
    exp_q.push_back(8'h5C);
    send_byte(8'h52, 1); send_byte(8'h02, 1); send_byte(8'h00, 1);
    get_byte(b, ok); e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin errors++; $display("FAIL pio_read: got %h (rx=%0d), required %h", b, ok, e); end
    st_wr_q.delete(); st_addr_q.delete(); st_wdata_q.delete(); st_len_q.delete();
    wait_idle(ok);
  endtask

  task automatic test_framing();
    logic [7:0] b, e;
    bit ok;
    int r0;
    r0 = req_rises;
    exp_q.push_back(8'h15);
    send_byte(8'h57, 1); send_byte(8'h01, 0);
    get_byte(b, ok); e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin errors++; $display("FAIL frame_resp: got %h (rx=%0d), required %h", b, ok, e); end
    checks++;
    if (req_rises != r0 || st_len_q.size() != 0) begin
      errors++; $display("FAIL frame_nobus: got %0d requests %0d strobes, required 0 0", req_rises - r0, st_len_q.size());
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL frame_idle: busy stuck at %b, required 0", busy); end
  endtask

  task automatic test_timeout();
    logic [7:0] b, e;
    bit ok;
    int r0, n;
    r0 = req_rises;
    send_byte(8'h57, 1); send_byte(8'h00, 1);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (n < TO - CPB || n > TO + CPB) begin
      errors++; $display("FAIL timeout_len: got busy drop after %0d clks, required %0d..%0d", n, TO - CPB, TO + CPB);
    end
    repeat (20 * CPB) @(negedge clk);
    checks++;
    if (got_q.size() != 0 || req_rises != r0) begin
      errors++; $display("FAIL timeout_silent: got %0d tx bytes %0d requests, required 0 0", got_q.size(), req_rises - r0);
    end
    exp_q.push_back(8'h06);
    send_byte(8'h57, 1); send_byte(8'h00, 1); send_byte(8'h44, 1); send_byte(8'h99, 1);
    get_byte(b, ok); e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin errors++; $display("FAIL timeout_next: got %h (rx=%0d), required %h", b, ok, e); end
    checks++;
    if (st_len_q.size() != 1 || st_addr_q[0] !== 16'h0044 || st_wdata_q[0] !== 8'h99) begin
      errors++; $display("FAIL timeout_next_bus: got %0d strobes, required one write of 99 at 0044", st_len_q.size());
    end
    st_wr_q.delete(); st_addr_q.delete(); st_wdata_q.delete(); st_len_q.delete();
    wait_idle(ok);
  endtask

  task automatic test_reset_mid_cycle();
    bit seen;
    gnt_delay = 30;
    send_byte(8'h57, 1); send_byte(8'h01, 1); send_byte(8'h50, 1); send_byte(8'h77, 1);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (wren === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstcyc_strobe: got wren=%b, required 1 before reset", wren); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (wren !== 1'b0 || rden !== 1'b0 || bus_req !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstcyc_state: got wren=%b rden=%b req=%b txd=%b busy=%b, required 0 0 0 1 0",
               wren, rden, bus_req, txd, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    gnt_delay = 0;
    repeat (20 * CPB) @(negedge clk);
    checks++;
    if (got_q.size() != 0 || st_len_q.size() != 0) begin
      errors++; $display("FAIL rstcyc_silent: got %0d tx bytes %0d strobes, required 0 0", got_q.size(), st_len_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b, e;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(8'hA5);
      send_byte(8'h52, 1); send_byte(8'h01, 1); send_byte(8'h23, 1);
      get_byte(b, ok); e = exp_q.pop_front();
      checks++;
      if (!ok || b !== e) begin errors++; $display("FAIL b2b_read%0d: got %h (rx=%0d), required %h", k, b, ok, e); end
      wait_idle(ok);
    end
    st_wr_q.delete(); st_addr_q.delete(); st_wdata_q.delete(); st_len_q.delete();
    checks++;
    if (viol != 0) begin errors++; $display("FAIL bus_rules: got %0d violations, required 0", viol); end
    checks++;
    if (tx_ferr != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL tx_frames: got %0d bad stops %0d pending, required 0 0", tx_ferr, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_grant_latency();
    test_bad_opcode();
    test_framing();
    test_timeout();
    test_reset_mid_cycle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Serial debug/loader initiator on the MCU memory bus: the initiator side of the bus that the RAM ($0000-$01FF) and PIO ($0200-$020F) respond on.
- Receives 8N1 UART command frames from a host, requests the bus from the CPU side, and performs single-byte read/write cycles.
- Returns an ACK byte or the read data over UART TX.
- Used to load RAM and poke PIO with the CPU held off the bus.

Parameters:
CLKS_PER_BIT, 30, clk cycles per UART bit (min 4)
BUS_CYCLES, 4, clk cycles each rden/wren strobe is held (min 2)
TIMEOUT, 65535, idle clk cycles allowed between bytes of one command before abort

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
rxd  input  1  UART receive line, idle high, asynchronous (synchronised internally)
txd  output  1  UART transmit line, idle high
bus_req  output  1  request for bus ownership
bus_gnt  input  1  grant from bus arbiter/top; level, may drop only after bus_req drops
addr  output  16  bus address
wdata  output  8  bus write data
rdata  input  8  bus read data from responder mux
wren  output  1  write strobe
rden  output  1  read strobe
busy  output  1  high while a command is being assembled or executed

Behaviour:
- Reset (rst=1 at posedge): txd=1, bus_req=0, addr=16'h0000, wdata=8'h00, wren=0, rden=0, busy=0. FSM=IDLE; RX/TX engines idle; counters cleared. Reset mid-byte or mid-cycle aborts everything; no partial bus cycle or TX byte continues.
- RX:
  - rxd passes through a 2-FF synchroniser.
  - Start is a falling edge while RX is idle. The start bit is re-sampled at CLKS_PER_BIT/2; if high it is a glitch and RX returns to idle.
  - Data bits are sampled every CLKS_PER_BIT, LSB first, followed by the stop bit.
  - Stop=1 gives rx_valid for one clk. Stop=0 is a framing error, flagged for one clk.
- TX:
  - On tx_start: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each CLKS_PER_BIT clocks.
  - tx_busy is high from tx_start until the stop bit ends.
- Command protocol (bytes):
  - Write: 0x57, addr_hi, addr_lo, data. Response 0x06 after the bus cycle.
  - Read: 0x52, addr_hi, addr_lo. Response is the byte read.
  - Any other opcode: response 0x15 (NAK), back to IDLE.
- FSM states: IDLE, ADDR_H, ADDR_L, DATA, REQ, CYCLE, RESP, WAIT_TX.
  - IDLE --rx_valid--> decode opcode. W or R goes to ADDR_H; other goes to RESP with 0x15.
  - ADDR_H --rx_valid--> ADDR_L. ADDR_L --rx_valid--> DATA if W, REQ if R. DATA --rx_valid--> REQ.
  - REQ: bus_req=1, wait for bus_gnt=1, then CYCLE.
  - CYCLE: addr valid from the first CYCLE clk. wren (W) or rden (R) is held for exactly BUS_CYCLES clks. rdata is captured on the last strobe clk. Strobe drops, then addr returns to 0, and next clk bus_req=0. Then RESP.
  - RESP: pulse tx_start with the response byte (wait if tx_busy), then WAIT_TX. WAIT_TX: on tx_busy=0, go to IDLE.
  - busy=1 in every state except IDLE.
- Bus rules:
  - wren/rden are never asserted unless bus_req and bus_gnt are both 1. Never both at once.
  - addr/wdata are stable for the whole strobe.
  - When idle, addr=0, wren=0, rden=0.
  - If bus_gnt drops during CYCLE (arbiter violation): strobes drop immediately, bus_req drops, response is 0x15.
- Abort conditions:
  - Framing error in ADDR_H/ADDR_L/DATA: return to IDLE and send 0x15.
  - Framing error in IDLE: ignored.
  - Inter-byte timeout: in ADDR_H/ADDR_L/DATA, no rx_valid for TIMEOUT clks returns silently to IDLE. The counter resets on each rx_valid.
  - Bytes arriving during REQ/CYCLE/RESP/WAIT_TX are discarded (no buffering).
- Address: full 16 bits are driven; no range check. Unmapped reads return whatever rdata holds.

Test Plan:
- Write then read: send 57 01 23 A5, bus model stores it -> one wren pulse of BUS_CYCLES clks at addr 0x0123 with wdata 0xA5, txd returns 0x06. Then send 52 01 23 -> rden pulse at 0x0123, txd returns 0xA5.
- Grant latency: hold bus_gnt=0 for 100 clks after bus_req rises -> no strobe before grant; strobe starts the clk after bus_gnt=1; bus_req falls after the strobe.
- Bad opcode 0x33 -> txd 0x15, no bus_req. A following 52 02 00 with rdata=0x5C -> txd 0x5C.
- Framing error: send 57, then 01 with stop=0 -> txd 0x15, no bus activity, FSM back to IDLE.
- Timeout: send 57 00 (no more) with TIMEOUT=200 -> busy falls at about 200 clks after the last byte; no tx, no bus_req. A next full command succeeds.
- Reset mid-cycle: assert rst during CYCLE -> next clk wren=0, rden=0, bus_req=0, txd=1, busy=0; no response byte is sent.
